// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage PC sequencer: FSM states and the
// next-PC source select codes used by pc_next_sel.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_PEND,
    ST_HALT_WAIT,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_PEND,
    SEL_TRAP
  } next_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC source mux plus the PC incrementer. The incremented value is also
// exported so the top can present it as the link-register value.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] INCR     = 32'd4,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] redir_target,
  input  logic [31:0] pend_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus_incr
);

  assign pc_plus_incr = pc + INCR;

  // Pick the source for the next PC (or for a deferred redirect target)
  always_comb begin
    next_pc = pc_plus_incr;
    case (next_sel_t'(sel))
      SEL_SEQ:   next_pc = pc_plus_incr;
      SEL_REDIR: next_pc = redir_target;
      SEL_PEND:  next_pc = pend_target;
      SEL_TRAP:  next_pc = TRAP_VEC;
      default:   next_pc = pc_plus_incr;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage. Issues fetch addresses over a
// valid/ready handshake and redirects on branch/jump resolution or halt.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, a redirect target
// with nonzero low bits is replaced by TRAP_VEC and misalign_o pulses; when
// undefined, the low two target bits are cleared and misalign_o stays 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INCR     = 32'd4,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_target_i,
  input  logic             halt_i,
  output logic             if_req_valid_o,
  input  logic             if_req_ready_i,
  output logic [31:0]      if_req_addr_o,
  output logic [31:0]      pc_plus_incr_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             halted_o,
  output logic             misalign_o
);

  state_t            state_q, state_d;
  logic [31:0]       pc_q;
  logic [31:0]       pend_target_q;
  logic              held_q, held_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic              misalign_q, mis_d;
  logic              pc_load, pend_load, cnt_inc;
  next_sel_t         sel, redir_sel;
  logic              tgt_mis;
  logic [31:0]       redir_aligned;
  logic [31:0]       next_pc;
  logic              fire;

`ifdef MISALIGN_TRAP_EN
  assign tgt_mis       = (redirect_target_i[1:0] != 2'b00);
  assign redir_aligned = redirect_target_i;
`else
  assign tgt_mis       = 1'b0;
  assign redir_aligned = redirect_target_i & ~32'h0000_0003;
`endif

  assign redir_sel      = tgt_mis ? SEL_TRAP : SEL_REDIR;
  assign if_req_valid_o = held_q | ((state_q == ST_RUN) & ~stall_i);
  assign fire           = if_req_valid_o & if_req_ready_i;
  assign if_req_addr_o  = pc_q;
  assign fetch_cnt_o    = fetch_cnt_q;
  assign halted_o       = (state_q == ST_HALTED);
  assign misalign_o     = misalign_q;

  pc_next_sel #(
    .INCR     (INCR),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .sel          (sel),
    .pc           (pc_q),
    .redir_target (redir_aligned),
    .pend_target  (pend_target_q),
    .next_pc      (next_pc),
    .pc_plus_incr (pc_plus_incr_o)
  );

  // Next-state, handshake hold and PC/pend-target load decisions
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    pend_d    = pend_q;
    pc_load   = 1'b0;
    pend_load = 1'b0;
    cnt_inc   = 1'b0;
    mis_d     = 1'b0;
    sel       = SEL_SEQ;
    case (state_q)
      ST_BOOT: state_d = halt_i ? ST_HALTED : ST_RUN;
      ST_RUN, ST_PEND, ST_HALT_WAIT: begin
        if (fire) begin
          pc_load = 1'b1;
          cnt_inc = 1'b1;
          held_d  = 1'b0;
          pend_d  = 1'b0;
          if (redirect_valid_i) begin
            sel   = redir_sel;
            mis_d = tgt_mis;
          end else if (pend_q) begin
            sel = SEL_PEND;
          end
          state_d = (halt_i || state_q == ST_HALT_WAIT) ? ST_HALTED : ST_RUN;
        end else if (if_req_valid_o) begin
          held_d = 1'b1;
          if (redirect_valid_i) begin
            pend_load = 1'b1;
            pend_d    = 1'b1;
            sel       = redir_sel;
            mis_d     = tgt_mis;
          end
          if (halt_i || state_q == ST_HALT_WAIT) state_d = ST_HALT_WAIT;
          else if (pend_q || redirect_valid_i)   state_d = ST_PEND;
          else                                   state_d = ST_RUN;
        end else begin
          if (redirect_valid_i) begin
            pc_load = 1'b1;
            sel     = redir_sel;
            mis_d   = tgt_mis;
          end
          state_d = halt_i ? ST_HALTED : ST_RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Register the FSM state, PC, deferred target, handshake hold and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pend_target_q <= RESET_PC;
      held_q        <= 1'b0;
      pend_q        <= 1'b0;
      fetch_cnt_q   <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      misalign_q <= mis_d;
      if (pc_load)   pc_q          <= next_pc;
      if (pend_load) pend_target_q <= next_pc;
      if (cnt_inc)   fetch_cnt_q   <= fetch_cnt_q + CNT_W'(1);
    end
  end

endmodule
